auth_verifier: RTL and testbench



---
 rtl/auth_pkg.sv | 19 +
 rtl/auth_verifier_sync_edge.sv | 25 ++
 rtl/auth_verifier.sv | 161 ++++++++++++++++
 tb/tb_auth_verifier.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared types and sizing helpers for the OTP authentication verifier.
package auth_pkg;

  localparam int ATTEMPT_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    GRANTED = 3'd2,
    DENIED  = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  // Counter width for a countdown that loads value-1; never narrower than one bit.
  function automatic int cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/auth_verifier_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a single-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/auth_verifier.sv
// Judges user-entered nibbles against a captured single-use OTP with attempt limit,
// validity timeout and lockout; all status outputs are registered.
module auth_verifier
  import auth_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RESULT_HOLD    = 25_000_000,
  parameter int LOCK_CYCLES    = 250_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           otp_value,
  input  logic                 otp_latch,
  input  logic [3:0]           user_in,
  input  logic                 user_latch,
  output logic                 grant,
  output logic                 deny,
  output logic                 locked,
  output logic                 expired,
  output logic [ATTEMPT_W-1:0] attempts_left,
  output logic [2:0]           state_code
);

  localparam int TW       = cnt_w(TIMEOUT_CYCLES);
  localparam int HOLD_MAX = (RESULT_HOLD > LOCK_CYCLES) ? RESULT_HOLD : LOCK_CYCLES;
  localparam int HW       = cnt_w(HOLD_MAX);

  localparam logic [TW-1:0]        TIMER_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0]        RESULT_LOAD  = HW'(RESULT_HOLD - 1);
  localparam logic [HW-1:0]        LOCK_LOAD    = HW'(LOCK_CYCLES - 1);
  localparam logic [ATTEMPT_W-1:0] ATTEMPT_LOAD = ATTEMPT_W'(MAX_ATTEMPTS);

  logic otp_pulse, user_pulse;
  logic [3:0] user_s1, user_s2;

  state_t                state, state_n;
  logic [3:0]            otp_reg, otp_n;
  logic [ATTEMPT_W-1:0]  attempts, attempts_n;
  logic [TW-1:0]         timer, timer_n;
  logic [HW-1:0]         hold, hold_n;
  logic                  expired_n;

  sync_edge u_otp_sync (
    .clk   (clk),
    .reset (reset),
    .din   (otp_latch),
    .pulse (otp_pulse)
  );

  sync_edge u_user_sync (
    .clk   (clk),
    .reset (reset),
    .din   (user_latch),
    .pulse (user_pulse)
  );

  always_comb begin
    state_n    = state;
    otp_n      = otp_reg;
    attempts_n = attempts;
    timer_n    = timer;
    hold_n     = hold;
    expired_n  = 1'b0;
    case (state)
      IDLE: begin
        if (otp_pulse) begin
          otp_n      = otp_value;
          attempts_n = ATTEMPT_LOAD;
          timer_n    = TIMER_LOAD;
          state_n    = ARMED;
        end
      end
      ARMED: begin
        if (user_pulse) begin
          if (user_s2 == otp_reg) begin
            otp_n      = '0;
            attempts_n = '0;
            timer_n    = '0;
            hold_n     = RESULT_LOAD;
            state_n    = GRANTED;
          end else if (attempts > ATTEMPT_W'(1)) begin
            attempts_n = attempts - 1'b1;
            hold_n     = RESULT_LOAD;
            state_n    = DENIED;
            if (timer != '0) timer_n = timer - 1'b1;
          end else begin
            otp_n      = '0;
            attempts_n = '0;
            timer_n    = '0;
            hold_n     = LOCK_LOAD;
            state_n    = LOCKED;
          end
        end else if (timer == '0) begin
          expired_n  = 1'b1;
          otp_n      = '0;
          attempts_n = '0;
          state_n    = IDLE;
        end else if (otp_pulse) begin
          otp_n      = otp_value;
          attempts_n = ATTEMPT_LOAD;
          timer_n    = TIMER_LOAD;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DENIED: begin
        // The OTP validity window keeps running while the denial is shown.
        if (timer == '0) begin
          expired_n  = 1'b1;
          otp_n      = '0;
          attempts_n = '0;
          hold_n     = '0;
          state_n    = IDLE;
        end else begin
          timer_n = timer - 1'b1;
          if (hold == '0) state_n = ARMED;
          else            hold_n  = hold - 1'b1;
        end
      end
      GRANTED, LOCKED: begin
        if (hold == '0) state_n = IDLE;
        else            hold_n  = hold - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      user_s1       <= '0;
      user_s2       <= '0;
      state         <= IDLE;
      otp_reg       <= '0;
      attempts      <= '0;
      timer         <= '0;
      hold          <= '0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      locked        <= 1'b0;
      expired       <= 1'b0;
      attempts_left <= '0;
    end else begin
      user_s1       <= user_in;
      user_s2       <= user_s1;
      state         <= state_n;
      otp_reg       <= otp_n;
      attempts      <= attempts_n;
      timer         <= timer_n;
      hold          <= hold_n;
      grant         <= (state_n == GRANTED);
      deny          <= (state_n == DENIED);
      locked        <= (state_n == LOCKED);
      expired       <= expired_n;
      attempts_left <= ((state_n == ARMED) || (state_n == DENIED)) ? attempts_n : '0;
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_auth_verifier.sv
// Self-checking bench for auth_verifier: vector table, directed corner sequences and
// randomized traffic compared each cycle against an absolute-time reference model.
module tb_auth_verifier;

  localparam int T_OUT = 100;
  localparam int HOLD  = 4;
  localparam int LOCK  = 20;
  localparam int MAXA  = 3;
  localparam int MAXC  = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] otp_value, user_in;
  logic       otp_latch, user_latch;
  logic       grant, deny, locked, expired;
  logic [1:0] attempts_left;
  logic [2:0] state_code;

  int checks = 0;
  int errors = 0;

  auth_verifier #(
    .MAX_ATTEMPTS   (MAXA),
    .TIMEOUT_CYCLES (T_OUT),
    .RESULT_HOLD    (HOLD),
    .LOCK_CYCLES    (LOCK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .otp_value     (otp_value),
    .otp_latch     (otp_latch),
    .user_in       (user_in),
    .user_latch    (user_latch),
    .grant         (grant),
    .deny          (deny),
    .locked        (locked),
    .expired       (expired),
    .attempts_left (attempts_left),
    .state_code    (state_code)
  );

  always #5 clk = ~clk;

  // Reference model: input history per edge, absolute deadlines instead of countdowns.
  bit       otp_h  [MAXC];
  bit       user_h [MAXC];
  bit [3:0] uval_h [MAXC];
  int cyc = 0;
  int last_rst = 0;
  int m_mode = 0;
  int m_otp = 0;
  int m_tries = 0;
  int m_deadline = 0;
  int m_end = 0;
  bit m_exp = 1'b0;

  function automatic bit f_otp(input int i);
    return (i <= last_rst || i < 1) ? 1'b0 : otp_h[i];
  endfunction
  function automatic bit f_usr(input int i);
    return (i <= last_rst || i < 1) ? 1'b0 : user_h[i];
  endfunction
  function automatic int f_uval(input int i);
    return (i <= last_rst || i < 1) ? 0 : int'(uval_h[i]);
  endfunction

  task automatic model_step();
    bit op, up;
    int uv;
    cyc++;
    otp_h[cyc]  = otp_latch;
    user_h[cyc] = user_latch;
    uval_h[cyc] = user_in;
    m_exp = 1'b0;
    if (reset) begin
      last_rst = cyc;
      m_mode = 0; m_otp = 0; m_tries = 0;
      return;
    end
    op = f_otp(cyc - 2) & ~f_otp(cyc - 3);
    up = f_usr(cyc - 2) & ~f_usr(cyc - 3);
    uv = f_uval(cyc - 2);
    case (m_mode)
      0: if (op) begin
        m_otp = int'(otp_value); m_tries = MAXA; m_deadline = cyc + T_OUT; m_mode = 1;
      end
      1: begin
        if (up) begin
          if (uv == m_otp) begin
            m_mode = 2; m_end = cyc + HOLD; m_otp = 0; m_tries = 0;
          end else if (m_tries > 1) begin
            m_tries--; m_mode = 3; m_end = cyc + HOLD;
          end else begin
            m_mode = 4; m_end = cyc + LOCK; m_otp = 0; m_tries = 0;
          end
        end else if (cyc >= m_deadline) begin
          m_exp = 1'b1; m_mode = 0; m_otp = 0; m_tries = 0;
        end else if (op) begin
          m_otp = int'(otp_value); m_tries = MAXA; m_deadline = cyc + T_OUT;
        end
      end
      3: begin
        if (cyc >= m_deadline) begin
          m_exp = 1'b1; m_mode = 0; m_otp = 0; m_tries = 0;
        end else if (cyc >= m_end) begin
          m_mode = 1;
        end
      end
      default: if (cyc >= m_end) m_mode = 0;
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int act_vec();
    return int'({grant, deny, locked, expired, attempts_left, state_code});
  endfunction

  function automatic int exp_vec();
    bit [1:0] a;
    a = (m_mode == 1 || m_mode == 3) ? 2'(m_tries) : 2'd0;
    return int'({m_mode == 2, m_mode == 3, m_mode == 4, m_exp, a, 3'(m_mode)});
  endfunction

  // One clock: inputs already set at the falling edge, model advances on the rising
  // edge, outputs compared at the next falling edge.
  task automatic tick();
    if (cyc + 1 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc + 1, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", act_vec(), exp_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic press_otp(input logic [3:0] v);
    otp_value = v; otp_latch = 1'b1; tick();
    otp_latch = 1'b0; tick(); tick();
  endtask

  task automatic press_user(input logic [3:0] v);
    user_in = v; user_latch = 1'b1; tick();
    user_latch = 1'b0; tick(); tick();
  endtask

  task automatic wait_state(input int code, input int budget);
    int n = 0;
    while (int'(state_code) != code && n < budget) begin
      tick(); n++;
    end
    check("wait_state", int'(state_code), code);
  endtask

  typedef struct {
    logic [3:0] otp;
    logic [3:0] usr;
    int         st;
    int         att;
    int         gr;
    int         dn;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{4'hA, 4'hA, 2, 0, 1, 0};
    vecs[1] = '{4'h5, 4'h3, 3, 2, 0, 1};
    vecs[2] = '{4'h0, 4'h0, 2, 0, 1, 0};
    vecs[3] = '{4'hF, 4'h7, 3, 2, 0, 1};
    vecs[4] = '{4'h8, 4'h8, 2, 0, 1, 0};

    reset = 1'b1; otp_value = 4'h0; user_in = 4'h0; otp_latch = 1'b0; user_latch = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_state", act_vec(), 0);

    foreach (vecs[i]) begin
      do_reset();
      press_otp(vecs[i].otp);
      check("vec_armed_state", int'(state_code), 1);
      check("vec_armed_attempts", int'(attempts_left), 3);
      press_user(vecs[i].usr);
      check("vec_state", int'(state_code), vecs[i].st);
      check("vec_attempts", int'(attempts_left), vecs[i].att);
      check("vec_grant", int'(grant), vecs[i].gr);
      check("vec_deny", int'(deny), vecs[i].dn);
    end

    // Correct entry: grant length and return to idle.
    do_reset();
    press_otp(4'hA);
    press_user(4'hA);
    n = int'(grant);
    for (int i = 0; i < 10; i++) begin tick(); if (grant) n++; end
    check("grant_cycles", n, HOLD);
    check("grant_end_state", int'(state_code), 0);
    check("grant_end_attempts", int'(attempts_left), 0);

    // Deny then grant.
    do_reset();
    press_otp(4'h5);
    press_user(4'h3);
    check("deny_attempts", int'(attempts_left), 2);
    n = int'(deny);
    for (int i = 0; i < 10; i++) begin tick(); if (deny) n++; end
    check("deny_cycles", n, HOLD);
    check("deny_back_armed", int'(state_code), 1);
    press_user(4'h5);
    check("deny_then_grant", int'(grant), 1);

    // Lockout with presses during the lock.
    do_reset();
    press_otp(4'h7);
    press_user(4'h0); wait_state(1, 20);
    press_user(4'h1); wait_state(1, 20);
    press_user(4'h2);
    n = int'(locked);
    for (int i = 0; i < 30; i++) begin
      otp_latch = (i >= 1 && i < 6); user_latch = otp_latch;
      tick(); if (locked) n++;
    end
    check("lock_cycles", n, LOCK);
    check("lock_end_state", int'(state_code), 0);

    // Expiry.
    do_reset();
    press_otp(4'h3);
    n = -1;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (expired) begin n = i; break; end
    end
    check("expiry_time", n, T_OUT);
    tick();
    check("expired_one_cycle", int'({expired, state_code}), 0);
    press_user(4'h3);
    check("user_after_expiry", int'(state_code), 0);

    // Simultaneous otp and user pulses: user wins, otp dropped.
    do_reset();
    press_otp(4'h9);
    user_in = 4'h9; otp_value = 4'h3; otp_latch = 1'b1; user_latch = 1'b1; tick();
    otp_latch = 1'b0; user_latch = 1'b0; tick(); tick();
    check("simul_grant", int'(grant), 1);
    for (int i = 0; i < 6; i++) tick();
    check("simul_no_rearm", int'(state_code), 0);

    // Held button: one judgement only.
    do_reset();
    press_otp(4'h4);
    user_in = 4'h2; user_latch = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    user_latch = 1'b0; tick(); tick(); tick();
    check("held_attempts", int'(attempts_left), 2);
    check("held_state", int'(state_code), 1);

    // Reset in the middle of a denial.
    do_reset();
    press_otp(4'hC);
    press_user(4'h1);
    check("pre_reset_deny", int'(deny), 1);
    do_reset();
    check("reset_mid_denied", act_vec(), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      otp_value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 14) == 0) otp_latch = ~otp_latch;
      if ($urandom_range(0, 9) == 0) begin
        user_latch = ~user_latch;
        user_in = ($urandom_range(0, 1) == 1) ? 4'(m_otp) : 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
